// File: rtl/he_frame_packer.sv
// Packs the equalised 8-bit pixel stream into 32-bit words with end-of-line/end-of-frame
// flags and presents them through a small first-word-fall-through FIFO on a valid/ready bus.
module he_frame_packer #(
  parameter int IMAGE_WIDTH  = 660,
  parameter int IMAGE_HEIGHT = 440,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic [31:0] word_out,
  output logic        word_eol,
  output logic        word_eof,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_done,
  output logic        overflow
);

  localparam int COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;

  typedef enum logic [1:0] {IDLE, PACK, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        byte_idx;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [23:0]       lanes;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [33:0]       mem [FIFO_DEPTH];
  logic [33:0]       head;
  logic              ovf_r;

  logic accept, push, wr_en, pop, last_pop;
  logic at_eol, at_eof;
  logic fifo_empty, fifo_full;

  assign accept     = pix_valid && ((state == IDLE) || (state == PACK));
  assign push       = accept && (byte_idx == 2'd3);
  assign at_eol     = (col == COL_W'(IMAGE_WIDTH - 1));
  assign at_eof     = at_eol && (row == ROW_W'(IMAGE_HEIGHT - 1));

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && word_ready;
  // A pop frees the slot the incoming word lands in, so a full FIFO still accepts it.
  assign wr_en      = push && (!fifo_full || pop);
  assign last_pop   = pop && ((wr_ptr - rd_ptr) == PW'(1));

  assign head       = mem[rd_ptr[AW-1:0]];
  assign word_valid = !fifo_empty;
  assign word_out   = word_valid ? head[31:0] : '0;
  assign word_eol   = word_valid && head[32];
  assign word_eof   = word_valid && head[33];
  assign frame_done = (state == DONE);
  assign overflow   = ovf_r;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PACK;
      PACK:    if (push && at_eof) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty || last_pop) state_nxt = DONE;
      default: state_nxt = DONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Framing counters advance on every accepted pixel, even when the word is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx <= '0;
      col      <= '0;
      row      <= '0;
      lanes    <= '0;
    end else if (accept) begin
      byte_idx <= byte_idx + 2'd1;
      case (byte_idx)
        2'd0:    lanes[7:0]   <= pix_in;
        2'd1:    lanes[15:8]  <= pix_in;
        2'd2:    lanes[23:16] <= pix_in;
        default: ;
      endcase
      if (at_eol) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {at_eof, at_eol, pix_in, lanes};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_r  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      if (push && !wr_en) ovf_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_he_frame_packer.sv
// Bench for he_frame_packer: a pixel-count/queue model checked every cycle on the falling
// edge, plus directed frames with literal word expectations on two parameterisations.
module tb_he_frame_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, pix_valid, word_ready, sel;
  logic [7:0]  pix_in;
  logic [31:0] a_word, b_word, d_word;
  logic        a_eol, a_eof, a_valid, a_done, a_ovf;
  logic        b_eol, b_eof, b_valid, b_done, b_ovf;
  logic        d_eol, d_eof, d_valid, d_done, d_ovf;

  he_frame_packer #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(2), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .pix_in(pix_in), .pix_valid(pix_valid),
    .word_out(a_word), .word_eol(a_eol), .word_eof(a_eof), .word_valid(a_valid),
    .word_ready(word_ready), .frame_done(a_done), .overflow(a_ovf));

  he_frame_packer #(.IMAGE_WIDTH(64), .IMAGE_HEIGHT(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .pix_in(pix_in), .pix_valid(pix_valid),
    .word_out(b_word), .word_eol(b_eol), .word_eof(b_eof), .word_valid(b_valid),
    .word_ready(word_ready), .frame_done(b_done), .overflow(b_ovf));

  always_comb begin
    d_word  = sel ? b_word  : a_word;
    d_eol   = sel ? b_eol   : a_eol;
    d_eof   = sel ? b_eof   : a_eof;
    d_valid = sel ? b_valid : a_valid;
    d_done  = sel ? b_done  : a_done;
    d_ovf   = sel ? b_ovf   : a_ovf;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is just pixel number n; every 4th pixel closes a word.
  logic [33:0] m_q[$];
  logic [7:0]  m_bytes[3];
  int          m_n;
  bit          m_ovf, m_done;
  int          cur_w = 8, cur_h = 2, cur_d = 8;
  logic [33:0] got[$];

  function automatic void model_clear();
    m_q.delete();
    m_n = 0;
    m_ovf = 0;
    m_done = 0;
  endfunction

  function automatic void model_step();
    bit pop = (m_q.size() > 0) && (word_ready === 1'b1);
    bit ended = (m_n >= cur_w * cur_h);
    logic [31:0] w;
    bit eol, eof;
    if (pop) void'(m_q.pop_front());
    if (pix_valid === 1'b1 && !ended) begin
      if (m_n % 4 < 3) m_bytes[m_n % 4] = pix_in;
      else begin
        w   = {pix_in, m_bytes[2], m_bytes[1], m_bytes[0]};
        eol = (m_n % cur_w) == cur_w - 1;
        eof = (m_n == cur_w * cur_h - 1);
        if (m_q.size() < cur_d) m_q.push_back({eof, eol, w});
        else m_ovf = 1;
      end
      m_n++;
    end
    if (m_n >= cur_w * cur_h && m_q.size() == 0) m_done = 1;
  endfunction

  always @(negedge clk) begin
    if (reset_n !== 1'b1) model_clear();
    check("word_valid", 64'(d_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("word_out", 64'(d_word), 64'(m_q[0][31:0]));
      check("word_eol", 64'(d_eol), 64'(m_q[0][32]));
      check("word_eof", 64'(d_eof), 64'(m_q[0][33]));
    end
    check("frame_done", 64'(d_done), 64'(m_done));
    check("overflow", 64'(d_ovf), 64'(m_ovf));
    if (d_valid && word_ready) got.push_back({d_eof, d_eol, d_word});
    if (reset_n === 1'b1) model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    pix_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic send(input logic [7:0] v);
    pix_valid = 1'b1;
    pix_in = v;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!d_done && c < budget) begin
      tick();
      c++;
    end
    check("done_within_budget", 64'(d_done), 64'd1);
  endtask

  logic [33:0] exp_small[4];

  task automatic check_small_words(input string name, input int base);
    check({name, "_count"}, 64'(got.size() - base), 64'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < got.size()) check({name, "_word"}, 64'(got[base + i]), 64'(exp_small[i]));
  endtask

  initial begin
    int base;
    int nx;
    bit pv;
    logic [33:0] pw;
    logic [33:0] e;

    exp_small[0] = {2'b00, 32'h03020100};
    exp_small[1] = {2'b01, 32'h07060504};
    exp_small[2] = {2'b00, 32'h0B0A0908};
    exp_small[3] = {2'b11, 32'h0F0E0D0C};

    sel = 1'b0; reset_n = 1'b0; pix_valid = 1'b0; pix_in = '0; word_ready = 1'b1;

    // 1: reset holds outputs low whatever the inputs do
    for (int i = 0; i < 6; i++) begin
      pix_valid = i[0];
      pix_in = 8'(i * 37);
      word_ready = ~i[1];
      tick();
      check("rst_outputs", {d_word, d_eol, d_eof, d_valid, d_done, d_ovf}, 64'd0);
    end
    reset_n = 1'b1; pix_valid = 1'b0; word_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_outputs", {d_word, d_eol, d_eof, d_valid, d_done, d_ovf}, 64'd0);
    end

    // 2: back-to-back streaming
    do_reset();
    base = got.size();
    for (int i = 0; i < 16; i++) begin
      pix_valid = 1'b1; pix_in = 8'(i);
      tick();
      if (i == 2) check("latency_before", 64'(d_valid), 64'd0);
      if (i == 3) check("latency_first", 64'(d_valid), 64'd1);
    end
    pix_valid = 1'b0;
    wait_done(40);
    check_small_words("stream", base);
    check("stream_overflow", 64'(d_ovf), 64'd0);

    // 3: random gaps between pixels
    do_reset();
    base = got.size();
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(8'(i));
    end
    wait_done(40);
    check_small_words("gapped", base);

    // 4: consumer stalls for 20 cycles mid-frame
    do_reset();
    base = got.size();
    for (int i = 0; i < 6; i++) send(8'(i));
    word_ready = 1'b0;
    nx = 6; pv = 0; pw = '0;
    for (int c = 0; c < 20; c++) begin
      if (c % 2 == 0 && nx < 16) begin
        pix_valid = 1'b1; pix_in = 8'(nx); nx++;
      end else pix_valid = 1'b0;
      tick();
      if (pv) begin
        check("stall_valid_held", 64'(d_valid), 64'd1);
        check("stall_word_held", 64'({d_eof, d_eol, d_word}), 64'(pw));
      end
      pv = d_valid;
      pw = {d_eof, d_eol, d_word};
    end
    pix_valid = 1'b0;
    word_ready = 1'b1;
    wait_done(40);
    check_small_words("stall", base);
    check("stall_overflow", 64'(d_ovf), 64'd0);

    // 5: overflow on the 64x1 / depth-4 instance
    reset_n = 1'b0; sel = 1'b1; cur_w = 64; cur_h = 1; cur_d = 4;
    word_ready = 1'b0;
    do_reset();
    base = got.size();
    for (int i = 0; i < 64; i++) begin
      pix_valid = 1'b1; pix_in = 8'(i);
      tick();
      if (i == 18) check("ovf_before_5th", 64'(d_ovf), 64'd0);
      if (i == 19) check("ovf_after_5th", 64'(d_ovf), 64'd1);
    end
    pix_valid = 1'b0;
    tick();
    word_ready = 1'b1;
    wait_done(40);
    check("ovf_count", 64'(got.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      e = {2'b00, 8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
      if (base + i < got.size()) check("ovf_word", 64'(got[base + i]), 64'(e));
    end
    check("ovf_sticky", 64'(d_ovf), 64'd1);

    // 6: reset mid-frame, then a full frame, then pixels after DONE
    reset_n = 1'b0; sel = 1'b0; cur_w = 8; cur_h = 2; cur_d = 8;
    do_reset();
    for (int i = 0; i < 5; i++) send(8'(8'h40 + i));
    reset_n = 1'b0;
    tick();
    check("midrst_outputs", {d_word, d_eol, d_eof, d_valid, d_done, d_ovf}, 64'd0);
    reset_n = 1'b1;
    tick();
    base = got.size();
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i));
    wait_done(40);
    check("midrst_count", 64'(got.size() - base), 64'd4);
    if (got.size() > base) check("midrst_first_word", 64'(got[base]), 64'({2'b00, 32'h83828180}));
    base = got.size();
    for (int i = 0; i < 8; i++) send(8'(i));
    repeat (4) tick();
    check("post_done_no_words", 64'(got.size() - base), 64'd0);
    check("post_done_valid", 64'(d_valid), 64'd0);
    check("post_done_sticky", 64'(d_done), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
